// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and constants for the HiLo multiply/divide engine.
package muldiv_pkg;

    localparam int          MULDIV_ITERS  = 32;
    localparam logic [31:0] MULDIV_DBZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MSUB  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    function automatic logic op_is_div(input logic [2:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // MADD/MSUB accumulate a signed product.
    function automatic logic op_is_signed(input logic [2:0] o);
        return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
    endfunction

    function automatic logic op_is_known(input logic [2:0] o);
        return o <= 3'd5;
    endfunction

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the remainder
// and subtract the divisor when it fits.
module hilo_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // The remainder stays below the divisor, so bit 32 of the difference is a clean borrow.
    assign w_shift = {i_rem, i_quo[31]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_rem   = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    assign o_quo   = {i_quo[30:0], ~w_diff[32]};

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MADD/MSUB engine producing {Hi, Lo} and its write strobe.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise DIV/DIVU complete as illegal ops.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int ITERS = MULDIV_ITERS
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [63:0] hilo_in,
    output logic        busy,
    output logic        done,
    output logic        hilo_we,
    output logic [63:0] result,
    output logic        div_by_zero,
    output logic        illegal_op
);

    localparam int            CW   = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    muldiv_state_t r_state;
    op_t           r_op;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_b;
    logic [63:0]   r_hilo_in;
    logic          r_neg_q;
    logic [CW-1:0] r_cnt;

    logic          w_legal;
    logic          w_op_div;
    logic          w_rs_neg;
    logic          w_rt_neg;
    logic [31:0]   w_rs_mag;
    logic [31:0]   w_rt_mag;
    logic [32:0]   w_mul_add;
    logic [31:0]   w_step_hi;
    logic [31:0]   w_step_lo;
    logic [63:0]   w_prod;
    logic [63:0]   w_sprod;
    logic [63:0]   w_fix;

`ifdef MULDIV_DIV_EN
    logic          r_neg_r;
    logic [31:0]   w_div_rem;
    logic [31:0]   w_div_quo;

    hilo_div_step u_div_step (
        .i_rem     (r_hi),
        .i_quo     (r_lo),
        .i_divisor (r_b),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_legal = op_is_known(op);
`else
    assign w_legal     = op_is_known(op) && !op_is_div(op);
    assign div_by_zero = 1'b0;
`endif

    assign w_op_div = op_is_div(op);
    assign w_rs_neg = op_is_signed(op) & rs_val[31];
    assign w_rt_neg = op_is_signed(op) & rt_val[31];
    assign w_rs_mag = w_rs_neg ? (32'd0 - rs_val) : rs_val;
    assign w_rt_mag = w_rt_neg ? (32'd0 - rt_val) : rt_val;

    // Shift-add multiply: Hi accumulates, Lo holds the unconsumed multiplier bits.
    assign w_mul_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);

    always_comb begin
        w_step_hi = w_mul_add[32:1];
        w_step_lo = {w_mul_add[0], r_lo[31:1]};
`ifdef MULDIV_DIV_EN
        if (op_is_div(r_op)) begin
            w_step_hi = w_div_rem;
            w_step_lo = w_div_quo;
        end
`endif
    end

    assign w_prod  = {r_hi, r_lo};
    assign w_sprod = r_neg_q ? (64'd0 - w_prod) : w_prod;

    always_comb begin
        w_fix = w_sprod;
        case (r_op)
            OP_MADD: w_fix = r_hilo_in + w_sprod;
            OP_MSUB: w_fix = r_hilo_in - w_sprod;
`ifdef MULDIV_DIV_EN
            // Quotient truncates toward zero; remainder follows the dividend's sign.
            OP_DIV, OP_DIVU: w_fix = {(r_neg_r ? (32'd0 - r_hi) : r_hi),
                                      (r_neg_q ? (32'd0 - r_lo) : r_lo)};
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_MULT;
            r_hi        <= '0;
            r_lo        <= '0;
            r_b         <= '0;
            r_hilo_in   <= '0;
            r_neg_q     <= 1'b0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hilo_we     <= 1'b0;
            illegal_op  <= 1'b0;
            result      <= '0;
`ifdef MULDIV_DIV_EN
            r_neg_r     <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            hilo_we    <= 1'b0;
            illegal_op <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_by_zero <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        r_op      <= op_t'(op);
                        r_hilo_in <= hilo_in;
                        r_cnt     <= '0;
                        r_neg_q   <= w_rs_neg ^ w_rt_neg;
                        r_hi      <= '0;
                        if (w_op_div) begin
                            r_lo <= w_rs_mag;
                            r_b  <= w_rt_mag;
                        end else begin
                            r_lo <= w_rt_mag;
                            r_b  <= w_rs_mag;
                        end
`ifdef MULDIV_DIV_EN
                        r_neg_r <= w_rs_neg;
`endif
                        if (!w_legal) begin
                            r_state    <= ST_DONE;
                            done       <= 1'b1;
                            illegal_op <= 1'b1;
                        end
`ifdef MULDIV_DIV_EN
                        else if (w_op_div && (rt_val == 32'd0)) begin
                            r_state     <= ST_DONE;
                            done        <= 1'b1;
                            hilo_we     <= 1'b1;
                            div_by_zero <= 1'b1;
                            result      <= {rs_val, MULDIV_DBZ_LO};
                        end
`endif
                        else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result  <= w_fix;
                    done    <= 1'b1;
                    hilo_we <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: requests push expectations, a monitor checks each done pulse.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic [63:0] hilo_in = 64'd0;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [63:0] result;
    logic        div_by_zero;
    logic        illegal_op;

    typedef struct {
        string       nm;
        logic [63:0] res;
        logic        we;
        logic        dbz;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [63:0] exp_last = 64'd0;

    hilo_muldiv_unit dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .hilo_in     (hilo_in),
        .busy        (busy),
        .done        (done),
        .hilo_we     (hilo_we),
        .result      (result),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_idle_wait: busy got 1 expected 0 within 200 cycles", nm);
        end
    endtask

    // legal=0 means the op must complete as illegal with the previous result held.
    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] h, input logic [63:0] res,
                         input bit legal, input bit dbz);
        exp_t e;
        wait_idle(nm);
        if (legal) exp_last = res;
        e.nm  = nm;
        e.res = exp_last;
        e.we  = legal;
        e.dbz = dbz;
        e.ill = !legal;
        e.lat = (legal && !dbz) ? 34 : 1;
        e.acc = cyc;
        sb.push_back(e);
        start   = 1'b1;
        op      = o;
        rs_val  = a;
        rt_val  = b;
        hilo_in = h;
        @(negedge Clk);
        start   = 1'b0;
        rs_val  = $urandom();
        rt_val  = $urandom();
        hilo_in = {$urandom(), $urandom()};
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", mon_e.nm);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (hilo_we && !done) begin
                n_cmp++;
                n_err++;
                $display("FAIL we_without_done: got hilo_we=1 expected 0 while done=0");
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done with result %h expected no done", result);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.nm, "_result"},  result, mon_e.res);
                    chk({mon_e.nm, "_hilo_we"}, 64'(hilo_we), 64'(mon_e.we));
                    chk({mon_e.nm, "_dbz"},     64'(div_by_zero), 64'(mon_e.dbz));
                    chk({mon_e.nm, "_illegal"}, 64'(illegal_op), 64'(mon_e.ill));
                    chk({mon_e.nm, "_latency"}, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                end
            end
        end
    end

    initial begin
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_busy",    64'(busy), 64'd0);
        chk("reset_done",    64'(done), 64'd0);
        chk("reset_hilo_we", 64'(hilo_we), 64'd0);
        chk("reset_result",  result, 64'd0);
        chk("reset_dbz",     64'(div_by_zero), 64'd0);
        chk("reset_illegal", 64'(illegal_op), 64'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        issue("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB, 1, 0);
        issue("multu_big", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'h0000_0001_FFFF_FFFE, 1, 0);
`ifdef MULDIV_DIV_EN
        issue("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1, 0);
        issue("divu_zero", OP_DIVU, 32'd100, 32'd0, 64'd0, 64'h0000_0064_FFFF_FFFF, 1, 1);
        issue("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 1, 0);
        issue("divu_big",  OP_DIVU, 32'hFFFF_FFFF, 32'd16, 64'd0, 64'h0000_000F_0FFF_FFFF, 1, 0);
`else
        issue("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 64'd0, 64'd0, 0, 0);
        issue("divu_zero", OP_DIVU, 32'd100, 32'd0, 64'd0, 64'd0, 0, 0);
`endif
        issue("madd",      OP_MADD,  32'd3, 32'd4, 64'd10, 64'd22, 1, 0);
        issue("msub",      OP_MSUB,  32'd3, 32'd4, 64'd10, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
        issue("illegal6",  3'd6,     32'd5, 32'd5, 64'd0, 64'd0, 0, 0);
        issue("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1, 0);
        issue("illegal7",  3'd7,     32'd1, 32'd1, 64'd0, 64'd0, 0, 0);

        // A second start during an op must be ignored entirely.
        issue("mult_repulse", OP_MULT, 32'h0001_0000, 32'h0003_0000, 64'd0, 64'h0000_0003_0000_0000, 1, 0);
        repeat (4) @(negedge Clk);
        start  = 1'b1;
        op     = OP_MULTU;
        rs_val = 32'hFFFF_FFFF;
        rt_val = 32'hFFFF_FFFF;
        @(negedge Clk);
        start = 1'b0;
        drain();

        // Abort an op with reset at cycle 12; it must never write HiLo.
        wait_idle("abort");
        start = 1'b1;
`ifdef MULDIV_DIV_EN
        op = OP_DIV;
`else
        op = OP_MULT;
`endif
        rs_val = 32'd1000;
        rt_val = 32'd7;
        @(negedge Clk);
        start = 1'b0;
        repeat (11) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_busy",    64'(busy), 64'd0);
        chk("abort_done",    64'(done), 64'd0);
        chk("abort_hilo_we", 64'(hilo_we), 64'd0);
        chk("abort_result",  result, 64'd0);
        chk("abort_dbz",     64'(div_by_zero), 64'd0);
        chk("abort_illegal", 64'(illegal_op), 64'd0);
        exp_last = 64'd0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (40) @(negedge Clk);
        chk("abort_idle_busy", 64'(busy), 64'd0);

        issue("mult_after_reset", OP_MULT, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 64'd0, 64'd32, 1, 0);
        drain();
        repeat (3) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
